// File: rtl/lc3_memory_interface.sv
// LC-3 memory/IO stage: sequences SRAM and device-register accesses for the
// microsequencer and hosts the KBSR/KBDR/DSR/DDR/MCR registers.
module lc3_memory_interface #(
   parameter int WAIT_STATES = 2,
   parameter int DEV_WAIT    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mio_en,
   input  logic        r_w,
   input  logic [15:0] mar,
   input  logic [15:0] mdr_in,
   output logic        ready,
   output logic [15:0] mem_data,
   output logic [15:0] sram_addr,
   output logic        sram_we,
   output logic [15:0] sram_wdata,
   input  logic [15:0] sram_rdata,
   input  logic        kb_valid,
   input  logic [7:0]  kb_data,
   output logic        kb_ready,
   output logic        disp_valid,
   output logic [7:0]  disp_data,
   input  logic        disp_ack,
   output logic        halt
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [15:0] DEV_BASE  = 16'hFE00;
   localparam logic [15:0] ADDR_KBSR = 16'hFE00;
   localparam logic [15:0] ADDR_KBDR = 16'hFE02;
   localparam logic [15:0] ADDR_DSR  = 16'hFE04;
   localparam logic [15:0] ADDR_DDR  = 16'hFE06;
   localparam logic [15:0] ADDR_MCR  = 16'hFFFE;
   // Counter is preloaded with N-1 so that exactly N cycles are spent in BUSY.
   localparam logic [3:0]  SRAM_LOAD = 4'(WAIT_STATES - 1);
   localparam logic [3:0]  DEV_LOAD  = 4'(DEV_WAIT - 1);

   state_t      state_reg, state_next;
   logic [15:0] addr_reg;
   logic [15:0] wdata_reg;
   logic        rw_reg;
   logic [3:0]  cnt_reg;
   logic [15:0] mem_data_reg;
   logic        kbsr_reg;
   logic [7:0]  kbdr_reg;
   logic        dsr_reg;
   logic        disp_valid_reg;
   logic [7:0]  disp_data_reg;
   logic [15:0] mcr_reg;

   logic        is_dev;
   logic        last_busy;
   logic        done_rd;
   logic        done_wr;
   logic [15:0] dev_rdata;

   assign is_dev    = (addr_reg >= DEV_BASE);
   assign last_busy = (state_reg == BUSY) && (cnt_reg == 4'd0);
   assign done_rd   = (state_reg == DONE) && !rw_reg;
   assign done_wr   = (state_reg == DONE) && rw_reg;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (mio_en) state_next = BUSY;
         BUSY:    if (cnt_reg == 4'd0) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      dev_rdata = 16'h0000;
      case (addr_reg)
         ADDR_KBSR: dev_rdata = {kbsr_reg, 15'b0};
         ADDR_KBDR: dev_rdata = {8'h00, kbdr_reg};
         ADDR_DSR:  dev_rdata = {dsr_reg, 15'b0};
         ADDR_MCR:  dev_rdata = mcr_reg;
         default:   dev_rdata = 16'h0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= IDLE;
         addr_reg  <= 16'h0000;
         wdata_reg <= 16'h0000;
         rw_reg    <= 1'b0;
         cnt_reg   <= 4'd0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE && mio_en) begin
            addr_reg  <= mar;
            wdata_reg <= mdr_in;
            rw_reg    <= r_w;
            cnt_reg   <= (mar >= DEV_BASE) ? DEV_LOAD : SRAM_LOAD;
         end else if (state_reg == BUSY && cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
         end
      end
   end

   // SRAM data arrives one cycle after the address, so it is taken at the end of BUSY.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mem_data_reg <= 16'h0000;
      end else if (last_busy && !rw_reg) begin
         mem_data_reg <= is_dev ? dev_rdata : sram_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         kbsr_reg       <= 1'b0;
         kbdr_reg       <= 8'h00;
         dsr_reg        <= 1'b1;
         disp_valid_reg <= 1'b0;
         disp_data_reg  <= 8'h00;
         mcr_reg        <= 16'h8000;
      end else begin
         if (kb_valid && !kbsr_reg) begin
            kbdr_reg <= kb_data;
            kbsr_reg <= 1'b1;
         end
         if (done_rd && addr_reg == ADDR_KBDR) begin
            kbsr_reg <= 1'b0;
         end
         if (disp_valid_reg && disp_ack) begin
            disp_valid_reg <= 1'b0;
            dsr_reg        <= 1'b1;
         end
         // A DDR write while the display is still busy is silently dropped.
         if (done_wr && addr_reg == ADDR_DDR && dsr_reg) begin
            disp_data_reg  <= wdata_reg[7:0];
            disp_valid_reg <= 1'b1;
            dsr_reg        <= 1'b0;
         end
         if (done_wr && addr_reg == ADDR_MCR) begin
            mcr_reg <= wdata_reg;
         end
      end
   end

   assign ready      = (state_reg == DONE);
   assign sram_we    = done_wr && !is_dev;
   assign sram_addr  = addr_reg;
   assign sram_wdata = wdata_reg;
   assign mem_data   = mem_data_reg;
   assign kb_ready   = ~kbsr_reg;
   assign disp_valid = disp_valid_reg;
   assign disp_data  = disp_data_reg;
   assign halt       = ~mcr_reg[15];

endmodule
